cayde_encoder: RTL

- R-type instruction encoder: the inverse of the core's R-type decode path. Accepts an ALU operation code plus register indices and emits a 32-bit RV32I OP-class instruction word.
- Used by the self-test instruction generator and the debug instruction-injection path to build instruction streams that the decoder consumes.
- Valid/ready handshakes on both sides, with a small output FIFO to absorb backpressure.

---
 rtl/cayde_encoder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/cayde_encoder.sv
// cayde_encoder: R-type instruction encoder with an output FIFO.
//
// Turns an ALU operation code plus register indices into a 32-bit RV32I
// OP-class instruction word. The word is buffered in a small FIFO so the
// consumer can apply backpressure. Operation codes 10 and above are illegal.
// An illegal request stores a NOP (addi x0,x0,0) with its illegal flag set,
// and it bumps a saturating counter.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   A producer holding valid while ready is low must keep its payload stable.
//   in_ready = !full && !flush. It never depends on out_ready, because
//   there is no bypass from input to output.
//   out_instr/out_illegal always show the FIFO head. They cannot change
//   while out_valid && !out_ready.
//
// Optional build macro: CAYDE_ENC_RD0_DROP_EN
//   When defined, a legal request with rd == 0 is accepted but not
//   enqueued, because writing x0 has no architectural effect. Illegal
//   requests with rd == 0 are still enqueued and counted.
//   When undefined, every accepted request is enqueued.

module cayde_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [6:0]              in_alu_op,
    input  logic [4:0]              in_rd,
    input  logic [4:0]              in_rs1,
    input  logic [4:0]              in_rs2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic                    out_illegal,
    output logic [CNT_W-1:0]        illegal_cnt,
    output logic [$clog2(DEPTH):0]  level
);

    // DEPTH must be a power of two and at least 2. The pointers wrap
    // naturally at AW bits, so no explicit modulo logic is needed.
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    localparam logic [6:0]  OPCODE_OP = 7'b0110011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ------------------------------------------------------------------
    // Encoder datapath
    // ------------------------------------------------------------------
    logic [6:0]  enc_funct7;
    logic [2:0]  enc_funct3;
    logic        enc_illegal;
    logic [31:0] enc_instr;

    // Map the ALU operation code to funct7/funct3 and flag unknown codes.
    always_comb begin
        enc_funct7  = F7_BASE;
        enc_funct3  = 3'b000;
        enc_illegal = 1'b0;
        case (in_alu_op)
            7'd0: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b000; end // ADD
            7'd1: begin enc_funct7 = F7_ALT;  enc_funct3 = 3'b000; end // SUB
            7'd2: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b100; end // XOR
            7'd3: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b111; end // AND
            7'd4: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b110; end // OR
            7'd5: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b001; end // SLL
            7'd6: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b010; end // SLT
            7'd7: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b011; end // SLTU
            7'd8: begin enc_funct7 = F7_BASE; enc_funct3 = 3'b101; end // SRL
            7'd9: begin enc_funct7 = F7_ALT;  enc_funct3 = 3'b101; end // SRA
            default: enc_illegal = 1'b1;
        endcase
    end

    // Illegal requests become a harmless NOP so downstream decode stays sane.
    assign enc_instr = enc_illegal ? NOP_INSTR
                                   : {enc_funct7, in_rs2, in_rs1, enc_funct3,
                                      in_rd, OPCODE_OP};

    // ------------------------------------------------------------------
    // Handshake control
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          accept;
    logic          drop;
    logic          push;
    logic          pop;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // Flush blocks new requests so that nothing lands in a FIFO being cleared.
    assign in_ready = !full && !flush;
    assign accept   = in_valid && in_ready;

`ifdef CAYDE_ENC_RD0_DROP_EN
    // Legal writes to x0 are dropped after acceptance. Illegal ones are kept
    // so that the consumer still sees the flagged NOP.
    assign drop = !enc_illegal && (in_rd == 5'd0);
`else
    assign drop = 1'b0;
`endif

    assign push = accept && !drop;
    // A pop in a flush cycle is ignored. The flush empties the FIFO anyway.
    assign pop  = out_valid && out_ready && !flush;

    // ------------------------------------------------------------------
    // FIFO storage: {illegal flag, instruction word}
    // ------------------------------------------------------------------
    logic [32:0] entry_mem [DEPTH];

    // Write the encoded entry at the tail. Storage itself needs no reset,
    // because the outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_mem[wr_ptr] <= {enc_illegal, enc_instr};
        end
    end

    // Pointer and occupancy bookkeeping. Flush wins over any push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Count accepted illegal requests, sticking at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (accept && enc_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output view of the FIFO head
    // ------------------------------------------------------------------
    logic [32:0] head_entry;

    assign head_entry  = entry_mem[rd_ptr];
    assign out_valid   = !empty;
    // Zero when empty so the consumer never sees stale or uninitialised data.
    assign out_instr   = out_valid ? head_entry[31:0] : 32'h0;
    assign out_illegal = out_valid && head_entry[32];

endmodule
